// File: rtl/sd_clk_div.sv
// SD card clock generator: programmable divisor, stop-in-low-phase,
// counted init bursts and clk-domain rise/fall strobes.
module sd_clk_div #(
  parameter int DIV_W    = 8,
  parameter int INIT_DIV = 61,
  parameter int BURST_W  = 8
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic [DIV_W-1:0]   div_i,
  input  logic               en_i,
  input  logic               start_i,
  input  logic [BURST_W-1:0] n_i,
  output logic               sd_clk,
  output logic               rise_o,
  output logic               fall_o,
  output logic               running_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DIV_W-1:0]   cnt;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   ph_div;
  logic [BURST_W-1:0] burst_cnt;

  logic active;
  logic hit;
  logic tog_rise;
  logic tog_fall;
  logic go_run;
  logic go_burst;
  logic last_fall;

  assign active    = (state != STOP);
  assign hit       = active && (cnt == ph_div);
  assign tog_rise  = hit && !sd_clk;
  assign tog_fall  = hit && sd_clk;
  assign go_run    = (state == STOP) && en_i;
  assign go_burst  = (state == STOP) && !en_i && start_i
                     && (n_i != '0);
  assign last_fall = (state == BURST) && tog_fall
                     && (burst_cnt == '0);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= STOP;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      STOP: begin
        if (go_run)        state_nx = RUN;
        else if (go_burst) state_nx = BURST;
      end
      RUN: begin
        if (tog_fall && !en_i) state_nx = STOP;
      end
      BURST: begin
        if (last_fall) state_nx = STOP;
      end
      default: state_nx = STOP;
    endcase
  end

  // div_q is captured on a fall; ph_div picks it up on the next rise so
  // both halves of every period share one divisor (exact 50% duty).
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sd_clk    <= 1'b0;
      rise_o    <= 1'b0;
      fall_o    <= 1'b0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
      cnt       <= '0;
      div_q     <= DIV_W'(INIT_DIV);
      ph_div    <= DIV_W'(INIT_DIV);
      burst_cnt <= '0;
    end else begin
      rise_o    <= tog_rise;
      fall_o    <= tog_fall;
      done_o    <= last_fall;
      running_o <= active;
      if (go_run || go_burst) begin
        div_q  <= div_i;
        ph_div <= div_i;
        cnt    <= '0;
      end else if (active) begin
        if (hit) begin
          cnt    <= '0;
          sd_clk <= ~sd_clk;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (tog_fall) div_q  <= div_i;
        if (tog_rise) ph_div <= div_q;
      end
      if (go_burst)
        burst_cnt <= n_i;
      else if ((state == BURST) && tog_rise)
        burst_cnt <= burst_cnt - 1'b1;
    end
  end

endmodule
